dcache_responder: RTL and testbench
===================================

# dcache_responder

Direct-mapped, write-through, no-write-allocate data cache that serves the `dcache_*` port driven by the writeback stage. It answers loads with one-cycle hit latency, and stalls the pipeline on a load miss or an unaccepted store. It forwards every store to main memory. It sits between the core's memory stage and the line-wide main-memory port.

## Interface
- `LINES`, 64: number of 16-byte lines; must be a power of two, at least 2.
- `clk` in 1: single clock; all state updates on the rising edge.
- `reset` in 1: asynchronous, active-low reset.
- `dcache_addr` in 32: byte address. Bits [1:0] are ignored for loads.
- `dcache_re` in 1: load request. The initiator qualifies this to load instructions only.
- `dcache_we` in 4: store byte-lane mask. Non-zero means store, and a store overrides `dcache_re`.
- `dcache_din` in 32: store data, already shifted to its byte lanes.
- `dcache_dout` out 32: load word, the aligned 32-bit word containing the load address.
- `dcache_stall` out 1: the pipeline must hold while this is high.
- `mem_req_valid` out 1: main-memory request valid.
- `mem_req_ready` in 1: main memory accepts the request.
- `mem_req_rnw` out 1: 1 means line read, 0 means masked write.
- `mem_req_addr` out 28: line address, equal to addr[31:4].
- `mem_req_data` out 128: write data.
- `mem_req_mask` out 16: write byte mask.
- `mem_resp_valid` in 1: fill data valid.
- `mem_resp_data` in 128: fill line. Word i occupies bits [32i+31:32i].
- `hit_count`, `miss_count` out 32 each: statistics outputs (see Configuration).

## Operation
- Address split:
  - offset = addr[3:2]
  - index = addr[4+log2(LINES)-1:4]
  - tag = the remaining upper bits
- Request sampling:
  - CPU inputs are registered at every rising edge where `dcache_stall`=0.
  - Inputs are ignored while stalled; the cache holds its own copy of the request.
- States: IDLE, WRITE, FILL_REQ, FILL_WAIT, REPLAY.
- IDLE, evaluated on the registered request:
  - Load hit: `dcache_dout` = stored word, `dcache_stall`=0.
  - Load miss: `dcache_stall`=1, go to FILL_REQ.
  - Store: `mem_req_valid`=1, `mem_req_rnw`=0.
    - Write data: `dcache_din` replicated into all four words.
    - Mask: `dcache_we` << (4·offset).
    - On a tag hit, the selected bytes of the line are updated at the same edge the request is accepted.
    - If `mem_req_ready`=1, then `dcache_stall`=0 and stay in IDLE; otherwise `dcache_stall`=1 and go to WRITE.
  - No request: idle, `dcache_stall`=0.
- WRITE: hold `mem_req_valid` and a stable payload. `dcache_stall`=1 until the cycle `mem_req_ready`=1, then return to IDLE.
- FILL_REQ: `mem_req_valid`=1, `mem_req_rnw`=1. Go to FILL_WAIT on `mem_req_ready`.
- FILL_WAIT: wait for `mem_resp_valid`, then write the line, tag and valid bit, and go to REPLAY.
- REPLAY: `dcache_dout` = requested word from the filled line, `dcache_stall`=0. Return to IDLE; the next CPU request is sampled at this edge.
- Store-miss does not allocate.
- `mem_resp_valid` outside FILL_WAIT is ignored.
- Tag hits on invalid lines never count as hits.
- `mem_req_*` payload is don't-care while `mem_req_valid`=0 and stable while valid and not ready.

## Timing
- Reset values:
  - state = IDLE; all valid bits = 0.
  - `dcache_stall`=0, `dcache_dout`=0, `mem_req_valid`=0.
  - Counters = 0.
  - Tag and data arrays are not reset.
- Load hit latency: address at edge T, data in cycle T+1, no stall.
- Load miss latency: stall from T+1 through fill completion, with data in the REPLAY cycle. Minimum 3 stalled cycles, reached with ready and response each one cycle.
- Store with `mem_req_ready`=1 in T+1: zero stall.
- Reset mid-fill or mid-write: the request is abandoned with no retry. A late `mem_resp_valid` arrives in IDLE and is ignored.
- `dcache_stall` is combinational from state and `mem_req_ready`; it has no combinational path from CPU inputs.

## Configuration
- `DCACHE_STATS_EN` defined:
  - `hit_count` increments in each IDLE cycle with a load hit.
  - `miss_count` increments on each IDLE→FILL_REQ transition.
  - Both counters are 32-bit, wrap on overflow, and reset to 0.
- Not defined: both ports are tied to 0 and no counter flops exist. The port list is unchanged.

## Structure
- `dcache_pkg`:
  - State enum.
  - `LINE_BYTES`=16 and `WORD_SEL_W`=2.
  - Line-address width (28).
  - Memory-request struct (rnw, addr, data, mask).
- Sub-module `dcache_tag_array`:
  - Holds tag storage and the valid bit vector; the valid bits use the asynchronous reset.
  - Write port for fill.
  - Combinational hit output for the registered index/tag.
- The data array stays in the top.

## Test plan
- After reset, load 0x0000_0100 with main memory word = 0xDEAD_BEEF, ready and response each after 1 cycle → stall for 3 cycles, REPLAY `dcache_dout`=0xDEAD_BEEF, `miss_count`=1.
- Repeat the load at 0x0000_0100 → next cycle `dcache_dout`=0xDEAD_BEEF, stall 0, `hit_count`=1.
- Store `dcache_we`=4'b0011, din=0x0000_1234 to 0x0000_0104 (hit), ready held 0 for 2 cycles → stall 2 cycles. Then `mem_req_mask`=16'h0030 and line-address 0x000_0010 are accepted; a subsequent load of 0x104 returns the updated low half 0x1234.
- Store to an uncached line 0x0000_2000 → one memory write issued, no fill; a following load of 0x2000 misses.
- Load 0x0000_0100 and 0x0000_0500 with LINES=64: both map to index 16 → second load evicts the first; reloading 0x100 misses again.
- Assert reset during FILL_WAIT, then pulse `mem_resp_valid` → state IDLE, stall 0, all lines invalid, response ignored.

Source files
------------

// File: rtl/dcache_pkg.sv
// Shared types and constants for the direct-mapped write-through data cache.
package dcache_pkg;

    localparam int LINE_BYTES  = 16;
    localparam int WORD_SEL_W  = 2;
    localparam int LINE_ADDR_W = 28;
    localparam int LINE_BITS   = LINE_BYTES * 8;

    typedef enum logic [2:0] {
        S_IDLE,
        S_WRITE,
        S_FILL_REQ,
        S_FILL_WAIT,
        S_REPLAY
    } state_t;

    typedef struct packed {
        logic                   rnw;
        logic [LINE_ADDR_W-1:0] addr;
        logic [LINE_BITS-1:0]   data;
        logic [LINE_BYTES-1:0]  mask;
    } mem_req_t;

endpackage

// File: rtl/dcache_tag_array.sv
// Tag storage plus per-line valid bits; valid bits clear on reset, tags do not.
module dcache_tag_array
    import dcache_pkg::*;
#(
    parameter int LINES = 64,
    parameter int IDX_W = $clog2(LINES),
    parameter int TAG_W = LINE_ADDR_W - IDX_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [IDX_W-1:0] idx_i,
    input  logic [TAG_W-1:0] tag_i,
    input  logic             fill_en_i,
    output logic             hit_o
);

    logic [LINES-1:0] valid_q;
    logic [TAG_W-1:0] tag_mem [LINES];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            valid_q <= '0;
        end else if (fill_en_i) begin
            valid_q[idx_i] <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (fill_en_i) begin
            tag_mem[idx_i] <= tag_i;
        end
    end

    assign hit_o = valid_q[idx_i] && (tag_mem[idx_i] == tag_i);

endmodule

// File: rtl/dcache_responder.sv
// Direct-mapped, write-through, no-write-allocate data cache with one-cycle load hits.
// Optional statistics counters are built only when DCACHE_STATS_EN is defined.
module dcache_responder
    import dcache_pkg::*;
#(
    parameter int LINES = 64
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [31:0]            dcache_addr,
    input  logic                   dcache_re,
    input  logic [3:0]             dcache_we,
    input  logic [31:0]            dcache_din,
    output logic [31:0]            dcache_dout,
    output logic                   dcache_stall,
    output logic                   mem_req_valid,
    input  logic                   mem_req_ready,
    output logic                   mem_req_rnw,
    output logic [LINE_ADDR_W-1:0] mem_req_addr,
    output logic [LINE_BITS-1:0]   mem_req_data,
    output logic [LINE_BYTES-1:0]  mem_req_mask,
    input  logic                   mem_resp_valid,
    input  logic [LINE_BITS-1:0]   mem_resp_data,
    output logic [31:0]            hit_count,
    output logic [31:0]            miss_count
);

    localparam int IDX_W = $clog2(LINES);
    localparam int TAG_W = LINE_ADDR_W - IDX_W;

    state_t      state_q, state_d;
    logic [31:2] addr_q;
    logic        re_q;
    logic [3:0]  we_q;
    logic [31:0] din_q;

    logic                  unused_addr_bits;
    logic [IDX_W-1:0]      idx;
    logic [TAG_W-1:0]      tag;
    logic [WORD_SEL_W-1:0] offset;
    logic                  is_store, is_load, hit;
    logic                  fill_en, store_wr;
    logic [LINE_BYTES-1:0] store_mask;
    logic [LINE_BITS-1:0]  store_data, line_rd;
    logic [31:0]           line_word;
    mem_req_t              mem_req;

    assign unused_addr_bits = ^dcache_addr[1:0];

    assign idx        = addr_q[4+IDX_W-1:4];
    assign tag        = addr_q[31:4+IDX_W];
    assign offset     = addr_q[3:2];
    assign is_store   = |we_q;
    assign is_load    = re_q && !is_store;
    assign store_mask = {12'b0, we_q} << {offset, 2'b00};
    assign store_data = {4{din_q}};

    assign fill_en  = (state_q == S_FILL_WAIT) && mem_resp_valid;
    // A store updates a resident line only on the edge memory accepts it.
    assign store_wr = is_store && mem_req_ready && hit &&
                      ((state_q == S_IDLE) || (state_q == S_WRITE));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            addr_q  <= '0;
            re_q    <= 1'b0;
            we_q    <= '0;
            din_q   <= '0;
        end else begin
            state_q <= state_d;
            if (!dcache_stall) begin
                addr_q <= dcache_addr[31:2];
                re_q   <= dcache_re;
                we_q   <= dcache_we;
                din_q  <= dcache_din;
            end
        end
    end

    dcache_tag_array #(
        .LINES (LINES),
        .IDX_W (IDX_W),
        .TAG_W (TAG_W)
    ) u_tags (
        .clk       (clk),
        .reset     (reset),
        .idx_i     (idx),
        .tag_i     (tag),
        .fill_en_i (fill_en),
        .hit_o     (hit)
    );

    // One byte-lane array per line byte so stores map onto byte-enable writes.
    generate
        for (genvar gi = 0; gi < LINE_BYTES; gi++) begin : g_lane
            logic [7:0] lane_mem [LINES];

            always_ff @(posedge clk) begin
                if (fill_en) begin
                    lane_mem[idx] <= mem_resp_data[8*gi +: 8];
                end else if (store_wr && store_mask[gi]) begin
                    lane_mem[idx] <= store_data[8*gi +: 8];
                end
            end

            assign line_rd[8*gi +: 8] = lane_mem[idx];
        end
    endgenerate

    assign line_word = line_rd[{offset, 5'b0} +: 32];

    always_comb begin
        state_d       = state_q;
        dcache_stall  = 1'b0;
        dcache_dout   = '0;
        mem_req_valid = 1'b0;
        mem_req.rnw   = 1'b0;
        mem_req.addr  = addr_q[31:4];
        mem_req.data  = store_data;
        mem_req.mask  = store_mask;
        unique case (state_q)
            S_IDLE: begin
                if (is_store) begin
                    mem_req_valid = 1'b1;
                    if (!mem_req_ready) begin
                        dcache_stall = 1'b1;
                        state_d      = S_WRITE;
                    end
                end else if (is_load) begin
                    if (hit) begin
                        dcache_dout = line_word;
                    end else begin
                        dcache_stall = 1'b1;
                        state_d      = S_FILL_REQ;
                    end
                end
            end
            S_WRITE: begin
                mem_req_valid = 1'b1;
                if (mem_req_ready) begin
                    state_d = S_IDLE;
                end else begin
                    dcache_stall = 1'b1;
                end
            end
            S_FILL_REQ: begin
                dcache_stall  = 1'b1;
                mem_req_valid = 1'b1;
                mem_req.rnw   = 1'b1;
                mem_req.mask  = '0;
                if (mem_req_ready) begin
                    state_d = S_FILL_WAIT;
                end
            end
            S_FILL_WAIT: begin
                dcache_stall = 1'b1;
                if (mem_resp_valid) begin
                    state_d = S_REPLAY;
                end
            end
            S_REPLAY: begin
                dcache_dout = line_word;
                state_d     = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign mem_req_rnw  = mem_req.rnw;
    assign mem_req_addr = mem_req.addr;
    assign mem_req_data = mem_req.data;
    assign mem_req_mask = mem_req.mask;

`ifdef DCACHE_STATS_EN
    logic [31:0] hit_q, miss_q;
    logic        hit_evt, miss_evt;

    assign hit_evt  = (state_q == S_IDLE) && is_load && hit;
    assign miss_evt = (state_q == S_IDLE) && is_load && !hit;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            hit_q  <= '0;
            miss_q <= '0;
        end else begin
            if (hit_evt)  hit_q  <= hit_q + 32'd1;
            if (miss_evt) miss_q <= miss_q + 32'd1;
        end
    end

    assign hit_count  = hit_q;
    assign miss_count = miss_q;
`else
    assign hit_count  = '0;
    assign miss_count = '0;
`endif

endmodule

// File: tb/tb_dcache_responder.sv
// Directed bench for dcache_responder: miss/fill, hit, stores with backpressure, eviction, reset mid-fill.
module tb_dcache_responder;

    localparam int STATS =
`ifdef DCACHE_STATS_EN
        1;
`else
        0;
`endif

    logic         clk = 1'b0;
    logic         reset;
    logic [31:0]  dcache_addr;
    logic         dcache_re;
    logic [3:0]   dcache_we;
    logic [31:0]  dcache_din;
    logic [31:0]  dcache_dout;
    logic         dcache_stall;
    logic         mem_req_valid;
    logic         mem_req_ready;
    logic         mem_req_rnw;
    logic [27:0]  mem_req_addr;
    logic [127:0] mem_req_data;
    logic [15:0]  mem_req_mask;
    logic         mem_resp_valid;
    logic [127:0] mem_resp_data;
    logic [31:0]  hit_count;
    logic [31:0]  miss_count;

    int checks = 0;
    int errors = 0;

    localparam logic [127:0] LINE_A = {32'h0, 32'h0, 32'h5566_7788, 32'hDEAD_BEEF};
    localparam logic [127:0] LINE_B = {32'h0, 32'h0, 32'h0, 32'hAABB_CCDD};
    localparam logic [127:0] LINE_C = {32'h0, 32'h0, 32'h0, 32'h5050_5050};
    localparam logic [127:0] LINE_D = {32'h0, 32'h0, 32'h0, 32'h0BAD_F00D};

    dcache_responder #(.LINES(64)) dut (
        .clk            (clk),
        .reset          (reset),
        .dcache_addr    (dcache_addr),
        .dcache_re      (dcache_re),
        .dcache_we      (dcache_we),
        .dcache_din     (dcache_din),
        .dcache_dout    (dcache_dout),
        .dcache_stall   (dcache_stall),
        .mem_req_valid  (mem_req_valid),
        .mem_req_ready  (mem_req_ready),
        .mem_req_rnw    (mem_req_rnw),
        .mem_req_addr   (mem_req_addr),
        .mem_req_data   (mem_req_data),
        .mem_req_mask   (mem_req_mask),
        .mem_resp_valid (mem_resp_valid),
        .mem_resp_data  (mem_resp_data),
        .hit_count      (hit_count),
        .miss_count     (miss_count)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        reset          = 1'b0;
        dcache_addr    = '0;
        dcache_re      = 1'b0;
        dcache_we      = '0;
        dcache_din     = '0;
        mem_req_ready  = 1'b0;
        mem_resp_valid = 1'b0;
        mem_resp_data  = '0;

        repeat (2) tick();
        #3;
        check("rst_stall", dcache_stall, 0);
        check("rst_dout", dcache_dout, 0);
        check("rst_req_valid", mem_req_valid, 0);
        check("rst_hit_count", hit_count, 0);
        check("rst_miss_count", miss_count, 0);

        tick(); reset = 1'b1;

        // Cold load of 0x100: three stalled cycles then replay.
        tick(); dcache_addr = 32'h100; dcache_re = 1'b1;
        tick(); dcache_re = 1'b0; #3;
        check("miss_stall", dcache_stall, 1);
        check("miss_no_req", mem_req_valid, 0);
        tick(); mem_req_ready = 1'b1; #3;
        check("fill_req_valid", mem_req_valid, 1);
        check("fill_req_rnw", mem_req_rnw, 1);
        check("fill_req_addr", mem_req_addr, 28'h10);
        check("fill_req_stall", dcache_stall, 1);
        tick(); mem_req_ready = 1'b0; mem_resp_valid = 1'b1; mem_resp_data = LINE_A; #3;
        check("fill_wait_stall", dcache_stall, 1);
        tick(); mem_resp_valid = 1'b0; mem_resp_data = '0;
        dcache_addr = 32'h100; dcache_re = 1'b1; #3;
        check("replay_dout", dcache_dout, 32'hDEAD_BEEF);
        check("replay_stall", dcache_stall, 0);
        check("miss_count_1", miss_count, STATS);

        // Repeat load hits with no stall.
        tick(); dcache_re = 1'b0; #3;
        check("hit_dout", dcache_dout, 32'hDEAD_BEEF);
        check("hit_stall", dcache_stall, 0);
        tick(); #3;
        check("hit_count_1", hit_count, STATS);
        check("idle_dout", dcache_dout, 0);

        // Store hit to 0x104 with two cycles of backpressure.
        dcache_addr = 32'h104; dcache_we = 4'b0011; dcache_din = 32'h0000_1234;
        tick(); dcache_we = '0; #3;
        check("st_stall_0", dcache_stall, 1);
        check("st_valid", mem_req_valid, 1);
        check("st_rnw", mem_req_rnw, 0);
        check("st_mask", mem_req_mask, 16'h0030);
        check("st_addr", mem_req_addr, 28'h10);
        check("st_data", mem_req_data, {4{32'h0000_1234}});
        tick(); #3;
        check("st_stall_1", dcache_stall, 1);
        check("st_mask_hold", mem_req_mask, 16'h0030);
        tick(); mem_req_ready = 1'b1; dcache_addr = 32'h104; dcache_re = 1'b1; #3;
        check("st_accept_stall", dcache_stall, 0);
        check("st_accept_valid", mem_req_valid, 1);
        check("st_accept_mask", mem_req_mask, 16'h0030);
        check("st_accept_addr", mem_req_addr, 28'h10);
        tick(); mem_req_ready = 1'b0; dcache_re = 1'b0; #3;
        check("st_load_dout", dcache_dout, 32'h5566_1234);
        check("st_load_stall", dcache_stall, 0);

        // Store miss to 0x2000 accepted at once; no allocation.
        dcache_addr = 32'h2000; dcache_we = 4'hF; dcache_din = 32'hAABB_CCDD; mem_req_ready = 1'b1;
        tick(); dcache_we = '0; #3;
        check("stm_stall", dcache_stall, 0);
        check("stm_valid", mem_req_valid, 1);
        check("stm_rnw", mem_req_rnw, 0);
        check("stm_addr", mem_req_addr, 28'h200);
        check("stm_mask", mem_req_mask, 16'h000F);
        dcache_addr = 32'h2000; dcache_re = 1'b1;
        tick(); dcache_re = 1'b0; mem_req_ready = 1'b0; #3;
        check("stm_noalloc_miss", dcache_stall, 1);
        check("stm_noalloc_noreq", mem_req_valid, 0);
        tick(); mem_req_ready = 1'b1; #3;
        check("stm_fill_rnw", mem_req_rnw, 1);
        check("stm_fill_addr", mem_req_addr, 28'h200);
        tick(); mem_req_ready = 1'b0; mem_resp_valid = 1'b1; mem_resp_data = LINE_B;
        tick(); mem_resp_valid = 1'b0; dcache_addr = 32'h500; dcache_re = 1'b1; #3;
        check("stm_replay_dout", dcache_dout, 32'hAABB_CCDD);
        check("miss_count_2", miss_count, 2 * STATS);

        // 0x500 shares index 16 with 0x100 and evicts it.
        tick(); dcache_re = 1'b0; #3;
        check("evict_miss", dcache_stall, 1);
        tick(); mem_req_ready = 1'b1; #3;
        check("evict_fill_addr", mem_req_addr, 28'h50);
        tick(); mem_req_ready = 1'b0; mem_resp_valid = 1'b1; mem_resp_data = LINE_C;
        tick(); mem_resp_valid = 1'b0; dcache_addr = 32'h100; dcache_re = 1'b1; #3;
        check("evict_replay_dout", dcache_dout, 32'h5050_5050);
        tick(); dcache_re = 1'b0; #3;
        check("reload_miss", dcache_stall, 1);
        tick(); mem_req_ready = 1'b1; #3;
        check("reload_fill_addr", mem_req_addr, 28'h10);
        check("miss_count_4", miss_count, 4 * STATS);

        // Reset while waiting for the fill response.
        tick(); mem_req_ready = 1'b0; #3;
        check("fw_stall", dcache_stall, 1);
        reset = 1'b0; #1;
        check("rst_mid_stall", dcache_stall, 0);
        check("rst_mid_valid", mem_req_valid, 0);
        check("rst_mid_dout", dcache_dout, 0);
        check("rst_mid_miss_count", miss_count, 0);
        tick(); tick(); reset = 1'b1; mem_resp_valid = 1'b1; mem_resp_data = LINE_A; #3;
        check("late_resp_stall", dcache_stall, 0);
        check("late_resp_valid", mem_req_valid, 0);
        tick(); mem_resp_valid = 1'b0; dcache_addr = 32'h0; dcache_re = 1'b1; #3;
        check("late_resp_ignored", dcache_stall, 0);
        tick(); dcache_re = 1'b0; #3;
        check("inv_miss_0", dcache_stall, 1);
        tick(); mem_req_ready = 1'b1; #3;
        check("inv_fill_addr", mem_req_addr, 28'h0);
        tick(); mem_req_ready = 1'b0; mem_resp_valid = 1'b1; mem_resp_data = LINE_D;
        tick(); mem_resp_valid = 1'b0; dcache_addr = 32'h500; dcache_re = 1'b1; #3;
        check("inv_replay_dout", dcache_dout, 32'h0BAD_F00D);
        check("miss_count_post_rst", miss_count, STATS);
        tick(); dcache_re = 1'b0; #3;
        check("inv_miss_500", dcache_stall, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
